// File: rtl/pipelined_ctrl_unit.sv
// MIPS32 main control: decodes the ID opcode and carries the control bundle
// through ID/EX, EX/MEM and MEM/WB, with load-use stall and flush bubbles.
module pipelined_ctrl_unit #(
  parameter int EXT_OPS = 1,
  parameter int ALUOP_W = 3,
  parameter int REG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         id_opcode,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               flush,
  output logic               stall,
  output logic               id_jump,
  output logic               ex_reg_dst,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_branch,
  output logic               ex_branch_ne,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_reg_write,
  output logic               wb_mem_to_reg
);

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               branch;
    logic               branch_ne;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
  } ctrl_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(3'b101);

  ctrl_t            dec;
  logic             dec_jump;
  logic             uses_rt;
  ctrl_t            id_ex;
  logic [REG_W-1:0] ex_rt;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             mem_reg_write;
  logic             mem_mem_to_reg;

  always_comb begin
    dec      = '0;
    dec_jump = 1'b0;
    uses_rt  = 1'b0;
    case (id_opcode)
      6'b000000: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_FUNC;
        uses_rt       = 1'b1;
      end
      6'b100011: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_op     = ALU_ADD;
      end
      6'b101011: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_op    = ALU_ADD;
        uses_rt       = 1'b1;
      end
      6'b000100: begin
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
        uses_rt    = 1'b1;
      end
      6'b000101: if (EXT_OPS != 0) begin
        dec.branch    = 1'b1;
        dec.branch_ne = 1'b1;
        dec.alu_op    = ALU_SUB;
        uses_rt       = 1'b1;
      end
      6'b000010: dec_jump = 1'b1;
      6'b001000: if (EXT_OPS != 0) begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      6'b001100: if (EXT_OPS != 0) begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_AND;
      end
      6'b001101: if (EXT_OPS != 0) begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_OR;
      end
      6'b001010: if (EXT_OPS != 0) begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_SLT;
      end
      default: ;
    endcase
  end

  // Load-use: the load in EX writes rt, which ID is about to read.
  assign ex_mem_read = id_ex.mem_read;
  assign stall = ex_mem_read && (ex_rt != '0) &&
                 ((ex_rt == id_rs) || ((ex_rt == id_rt) && uses_rt));
  assign id_jump = dec_jump && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex          <= '0;
      ex_rt          <= '0;
      ex_mem_write   <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
    end else begin
      // A killed or stalled ID instruction becomes a bubble in EX.
      if (flush || stall) begin
        id_ex <= '0;
        ex_rt <= '0;
      end else begin
        id_ex <= dec;
        ex_rt <= id_rt;
      end
      ex_mem_write   <= 1'b0;
      mem_read       <= id_ex.mem_read;
      mem_write      <= id_ex.mem_write;
      mem_reg_write  <= id_ex.reg_write;
      mem_mem_to_reg <= id_ex.mem_to_reg;
      wb_reg_write   <= mem_reg_write;
      wb_mem_to_reg  <= mem_mem_to_reg;
    end
  end

  assign ex_reg_dst   = id_ex.reg_dst;
  assign ex_alu_src   = id_ex.alu_src;
  assign ex_alu_op    = id_ex.alu_op;
  assign ex_branch    = id_ex.branch;
  assign ex_branch_ne = id_ex.branch_ne;

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Bench for pipelined_ctrl_unit: stimulus table with expected ID decode and
// stall, expected stage contents tracked in a queue.
module tb_pipelined_ctrl_unit;
  localparam int W = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt;
  logic       flush;

  logic       stall, id_jump, ex_reg_dst, ex_alu_src, ex_branch, ex_branch_ne;
  logic [2:0] ex_alu_op;
  logic       mem_read, mem_write, wb_reg_write, wb_mem_to_reg;

  logic       stall_n, id_jump_n, ex_reg_dst_n, ex_alu_src_n, ex_branch_n, ex_branch_ne_n;
  logic [2:0] ex_alu_op_n;
  logic       mem_read_n, mem_write_n, wb_reg_write_n, wb_mem_to_reg_n;

  pipelined_ctrl_unit #(.EXT_OPS(1), .ALUOP_W(3), .REG_W(5)) u_dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .flush(flush), .stall(stall), .id_jump(id_jump), .ex_reg_dst(ex_reg_dst),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_branch(ex_branch),
    .ex_branch_ne(ex_branch_ne), .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg)
  );

  pipelined_ctrl_unit #(.EXT_OPS(0), .ALUOP_W(3), .REG_W(5)) u_dut_base (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .flush(flush), .stall(stall_n), .id_jump(id_jump_n), .ex_reg_dst(ex_reg_dst_n),
    .ex_alu_src(ex_alu_src_n), .ex_alu_op(ex_alu_op_n), .ex_branch(ex_branch_n),
    .ex_branch_ne(ex_branch_ne_n), .mem_read(mem_read_n), .mem_write(mem_write_n),
    .wb_reg_write(wb_reg_write_n), .wb_mem_to_reg(wb_mem_to_reg_n)
  );

  always #5 clk = ~clk;

  // Bundle bits: reg_dst, alu_src, alu_op[2:0], branch, branch_ne,
  // mem_read, mem_write, reg_write, mem_to_reg.
  localparam logic [W-1:0] B_NOP  = 11'b0_0_000_0_0_0_0_0_0;
  localparam logic [W-1:0] B_R    = 11'b1_0_010_0_0_0_0_1_0;
  localparam logic [W-1:0] B_LW   = 11'b0_1_000_0_0_1_0_1_1;
  localparam logic [W-1:0] B_SW   = 11'b0_1_000_0_0_0_1_0_0;
  localparam logic [W-1:0] B_BEQ  = 11'b0_0_001_1_0_0_0_0_0;
  localparam logic [W-1:0] B_BNE  = 11'b0_0_001_1_1_0_0_0_0;
  localparam logic [W-1:0] B_ADDI = 11'b0_1_000_0_0_0_0_1_0;
  localparam logic [W-1:0] B_ANDI = 11'b0_1_011_0_0_0_0_1_0;
  localparam logic [W-1:0] B_ORI  = 11'b0_1_100_0_0_0_0_1_0;
  localparam logic [W-1:0] B_SLTI = 11'b0_1_101_0_0_0_0_1_0;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI = 6'b001101, OP_SLTI = 6'b001010, OP_BAD = 6'b000011;

  typedef struct {
    logic [5:0]   op;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic         fl;
    logic [W-1:0] bundle;
    logic         exp_stall;
    logic         exp_jump;
    logic         chk_base;
    logic [W-1:0] bundle_base;
  } vec_t;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  vec_t vecs[0:28];

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic fl, input logic [W-1:0] bundle, input logic exp_stall,
                              input logic exp_jump, input logic chk_base,
                              input logic [W-1:0] bundle_base);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.fl = fl; v.bundle = bundle;
    v.exp_stall = exp_stall; v.exp_jump = exp_jump;
    v.chk_base = chk_base; v.bundle_base = bundle_base;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_pipe(input string tag);
    logic [W-1:0] e, m, w;
    e = exp_q[exp_q.size()-1];
    m = exp_q[exp_q.size()-2];
    w = exp_q[exp_q.size()-3];
    check({tag, " ex"}, 16'({ex_reg_dst, ex_alu_src, ex_alu_op, ex_branch, ex_branch_ne}), 16'(e[10:4]));
    check({tag, " mem"}, 16'({mem_read, mem_write}), 16'(m[3:2]));
    check({tag, " wb"}, 16'({wb_reg_write, wb_mem_to_reg}), 16'(w[1:0]));
  endtask

  task automatic reset_queue();
    exp_q.delete();
    repeat (3) exp_q.push_back(B_NOP);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input vec_t v, input string tag);
    logic [W-1:0] exp_ex, exp_base;
    id_opcode = v.op; id_rs = v.rs; id_rt = v.rt; flush = v.fl;
    #2;
    check({tag, " stall"}, 16'(stall), 16'(v.exp_stall));
    check({tag, " id_jump"}, 16'(id_jump), 16'(v.exp_jump));
    exp_ex = (v.fl || v.exp_stall) ? B_NOP : v.bundle;
    exp_base = v.fl ? B_NOP : v.bundle_base;
    @(posedge clk);
    #1;
    exp_q.push_back(exp_ex);
    if (exp_q.size() > 3) void'(exp_q.pop_front());
    check_pipe(tag);
    if (v.chk_base)
      check({tag, " base ex"}, 16'({ex_reg_dst_n, ex_alu_src_n, ex_alu_op_n, ex_branch_n, ex_branch_ne_n}),
            16'(exp_base[10:4]));
  endtask

  initial begin
    //               op       rs  rt  fl  bundle  stall jump chk base
    vecs[0]  = mk(OP_LW,   1,  2,  0, B_LW,   0, 0, 0, B_NOP);
    vecs[1]  = mk(OP_R,    3,  4,  0, B_R,    0, 0, 0, B_NOP);
    vecs[2]  = mk(OP_SW,   3,  6,  0, B_SW,   0, 0, 0, B_NOP);
    vecs[3]  = mk(OP_BAD,  0,  0,  0, B_NOP,  0, 0, 0, B_NOP);
    vecs[4]  = mk(OP_LW,   1,  5,  0, B_LW,   0, 0, 0, B_NOP);
    vecs[5]  = mk(OP_R,    5,  9,  0, B_R,    1, 0, 0, B_NOP);
    vecs[6]  = mk(OP_R,    5,  9,  0, B_R,    0, 0, 0, B_NOP);
    vecs[7]  = mk(OP_LW,   1,  0,  0, B_LW,   0, 0, 0, B_NOP);
    vecs[8]  = mk(OP_R,    0,  0,  0, B_R,    0, 0, 0, B_NOP);
    vecs[9]  = mk(OP_LW,   2,  7,  0, B_LW,   0, 0, 0, B_NOP);
    vecs[10] = mk(OP_ADDI, 3,  7,  0, B_ADDI, 0, 0, 0, B_NOP);
    vecs[11] = mk(OP_LW,   2,  7,  0, B_LW,   0, 0, 0, B_NOP);
    vecs[12] = mk(OP_SW,   3,  7,  0, B_SW,   1, 0, 0, B_NOP);
    vecs[13] = mk(OP_SW,   3,  7,  0, B_SW,   0, 0, 0, B_NOP);
    vecs[14] = mk(OP_BNE,  1,  2,  0, B_BNE,  0, 0, 1, B_NOP);
    vecs[15] = mk(OP_ORI,  1,  2,  0, B_ORI,  0, 0, 1, B_NOP);
    vecs[16] = mk(OP_ANDI, 1,  2,  0, B_ANDI, 0, 0, 0, B_NOP);
    vecs[17] = mk(OP_SLTI, 1,  2,  0, B_SLTI, 0, 0, 0, B_NOP);
    vecs[18] = mk(OP_BEQ,  1,  2,  0, B_BEQ,  0, 0, 1, B_BEQ);
    vecs[19] = mk(OP_BEQ,  1,  2,  1, B_BEQ,  0, 0, 1, B_BEQ);
    vecs[20] = mk(OP_J,    0,  0,  1, B_NOP,  0, 0, 0, B_NOP);
    vecs[21] = mk(OP_J,    0,  0,  0, B_NOP,  0, 1, 0, B_NOP);
    vecs[22] = mk(OP_LW,   1,  8,  0, B_LW,   0, 0, 0, B_NOP);
    vecs[23] = mk(OP_R,    8,  1,  1, B_R,    1, 0, 0, B_NOP);
    vecs[24] = mk(OP_ADDI, 1,  3,  0, B_ADDI, 0, 0, 0, B_NOP);
    vecs[25] = mk(OP_R,    1,  1,  0, B_R,    0, 0, 0, B_NOP);
    vecs[26] = mk(OP_BAD,  0,  0,  0, B_NOP,  0, 0, 0, B_NOP);
    vecs[27] = mk(OP_BAD,  0,  0,  0, B_NOP,  0, 0, 0, B_NOP);
    vecs[28] = mk(OP_BAD,  0,  0,  0, B_NOP,  0, 0, 0, B_NOP);

    // Reset with a live load in ID.
    rst = 1'b1; id_opcode = OP_LW; id_rs = 5'd1; id_rt = 5'd2; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_queue();
    check_pipe("reset");
    check("reset stall", 16'(stall), 16'd0);
    rst = 1'b0;

    for (int i = 0; i <= 28; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Reset while bundles are in flight.
    step(mk(OP_LW, 1, 2, 0, B_LW, 0, 0, 0, B_NOP), "pre_rst0");
    step(mk(OP_SW, 1, 2, 0, B_SW, 1, 0, 0, B_NOP), "pre_rst1");
    rst = 1'b1; id_opcode = OP_LW; id_rs = 5'd2; id_rt = 5'd2;
    @(posedge clk);
    #1;
    reset_queue();
    check_pipe("mid_rst");
    check("mid_rst stall", 16'(stall), 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      step(mk(OP_R, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 0, B_R, 0, 0, 0, B_NOP),
           $sformatf("post_rst%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
